// File: rtl/example_mul_pipe_mac.sv
// example_mul_pipe_mac: pipelined multiply / multiply-accumulate unit.
// Operands are registered in stage 1. The product is then carried through
// NUM_STAGE-2 product registers. The final stage is the accumulator (dout),
// which saturates or wraps on overflow and keeps a sticky overflow flag.
module example_mul_pipe_mac #(
  parameter int DIN0_WIDTH  = 7,
  parameter int DIN1_WIDTH  = 14,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int DOUT_WIDTH  = 21,
  parameter int NUM_STAGE   = 3,
  parameter int SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  // Full product width, and the width used for the accumulate arithmetic.
  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int SW  = DOUT_WIDTH + 1;
  localparam int NPR = NUM_STAGE - 2;

  localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  // Stage-1 registers.
  logic [DIN0_WIDTH-1:0] din0_r;
  logic [DIN1_WIDTH-1:0] din1_r;
  logic                  v1_r;
  logic                  en1_r;
  logic                  clr1_r;

  // Operands with one extra bit: sign-extended or zero-extended.
  logic signed [DIN0_WIDTH:0] a_ext_s;
  logic signed [DIN1_WIDTH:0] b_ext_s;
  logic signed [PW-1:0]       prod_s;

  // Final-stage inputs, after the product pipeline.
  logic signed [PW-1:0] p_fin_s;
  logic                 v_fin_s;
  logic                 en_fin_s;
  logic                 clr_fin_s;

  // Accumulator state and its next-state terms.
  logic signed [DOUT_WIDTH-1:0] dout_r;
  logic                         ovf_r;
  logic                         out_valid_r;
  logic signed [SW-1:0]         base_s;
  logic signed [SW-1:0]         sum_s;
  logic                         ov_s;
  logic [DOUT_WIDTH-1:0]        next_dout_s;
  logic                         next_ovf_s;

  // Stage 1: capture operands and sideband on every enabled edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      din0_r <= {DIN0_WIDTH{1'b0}};
      din1_r <= {DIN1_WIDTH{1'b0}};
      v1_r   <= 1'b0;
      en1_r  <= 1'b0;
      clr1_r <= 1'b0;
    end else if (ce) begin
      din0_r <= din0;
      din1_r <= din1;
      v1_r   <= in_valid;
      en1_r  <= acc_en;
      clr1_r <= acc_clr;
    end
  end

  // Extend both operands by one bit and form the signed full-width product.
  always_comb begin
    a_ext_s = {((DIN0_SIGNED != 0) & din0_r[DIN0_WIDTH-1]), din0_r};
    b_ext_s = {((DIN1_SIGNED != 0) & din1_r[DIN1_WIDTH-1]), din1_r};
    prod_s  = PW'(a_ext_s) * PW'(b_ext_s);
  end

  generate
    if (NPR == 0) begin : g_no_preg
      assign p_fin_s   = prod_s;
      assign v_fin_s   = v1_r;
      assign en_fin_s  = en1_r;
      assign clr_fin_s = clr1_r;
    end else begin : g_preg
      logic signed [PW-1:0] p_pipe_r [NPR];
      logic [NPR-1:0]       v_pipe_r;
      logic [NPR-1:0]       en_pipe_r;
      logic [NPR-1:0]       clr_pipe_r;

      // Product pipeline: shift the product and its sideband one stage per enabled edge.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int k = 0; k < NPR; k++) begin
            p_pipe_r[k]   <= {PW{1'b0}};
            v_pipe_r[k]   <= 1'b0;
            en_pipe_r[k]  <= 1'b0;
            clr_pipe_r[k] <= 1'b0;
          end
        end else if (ce) begin
          p_pipe_r[0]   <= prod_s;
          v_pipe_r[0]   <= v1_r;
          en_pipe_r[0]  <= en1_r;
          clr_pipe_r[0] <= clr1_r;
          for (int k = 1; k < NPR; k++) begin
            p_pipe_r[k]   <= p_pipe_r[k-1];
            v_pipe_r[k]   <= v_pipe_r[k-1];
            en_pipe_r[k]  <= en_pipe_r[k-1];
            clr_pipe_r[k] <= clr_pipe_r[k-1];
          end
        end
      end

      assign p_fin_s   = p_pipe_r[NPR-1];
      assign v_fin_s   = v_pipe_r[NPR-1];
      assign en_fin_s  = en_pipe_r[NPR-1];
      assign clr_fin_s = clr_pipe_r[NPR-1];
    end
  endgenerate

  // Accumulate or load, detect overflow, then clamp or wrap to the dout width.
  always_comb begin
    base_s      = {SW{1'b0}};
    sum_s       = {SW{1'b0}};
    ov_s        = 1'b0;
    next_dout_s = {DOUT_WIDTH{1'b0}};
    next_ovf_s  = 1'b0;
    if (clr_fin_s || !en_fin_s) begin
      base_s = {SW{1'b0}};
    end else begin
      base_s = SW'(dout_r);
    end
    sum_s = base_s + SW'(p_fin_s);
    ov_s  = sum_s[SW-1] ^ sum_s[SW-2];
    if (!ov_s) begin
      next_dout_s = sum_s[DOUT_WIDTH-1:0];
    end else if (SATURATE != 0) begin
      next_dout_s = sum_s[SW-1] ? DOUT_MIN : DOUT_MAX;
    end else begin
      next_dout_s = sum_s[DOUT_WIDTH-1:0];
    end
    if (clr_fin_s) begin
      next_ovf_s = ov_s;
    end else begin
      next_ovf_s = ovf_r | ov_s;
    end
  end

  // Final stage: update the accumulator only on valid beats; the valid flag follows the pipe.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_r <= 1'b0;
      dout_r      <= {DOUT_WIDTH{1'b0}};
      ovf_r       <= 1'b0;
    end else if (ce) begin
      out_valid_r <= v_fin_s;
      if (v_fin_s) begin
        dout_r <= next_dout_s;
        ovf_r  <= next_ovf_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign dout      = dout_r;
  assign ovf       = ovf_r;

endmodule
